// File: rtl/wall_spawner_if.sv
// Control and slot-readout bundle for wall_spawner.
// The master side (game logic) drives spawn control and clears;
// the slave side (the spawner) returns the slot contents and status.
interface wall_spawner_if #(
    parameter int NUM_WALLS = 4,
    parameter int COORD_W   = 11
);
    logic                         spawn_en;
    logic [NUM_WALLS-1:0]         clear;
    logic                         seed_load;
    logic [15:0]                  seed_data;
    logic [NUM_WALLS*COORD_W-1:0] wall_x;
    logic [NUM_WALLS*COORD_W-1:0] wall_y;
    logic [NUM_WALLS-1:0]         wall_valid;
    logic                         spawned;
    logic                         busy;

    modport master (
        output spawn_en, clear, seed_load, seed_data,
        input  wall_x, wall_y, wall_valid, spawned, busy
    );

    modport slave (
        input  spawn_en, clear, seed_load, seed_data,
        output wall_x, wall_y, wall_valid, spawned, busy
    );
endinterface

// File: rtl/wall_spawner.sv
// Obstacle generator: keeps NUM_WALLS wall slots filled with random on-screen
// positions. A free-running 16-bit Fibonacci LFSR supplies candidates; any
// candidate that would push the wall past the screen edge is rejected and the
// next LFSR value is tried on the following cycle.
module wall_spawner #(
    parameter int          NUM_WALLS = 4,
    parameter int          COORD_W   = 11,
    parameter int          X_MAX     = 640,
    parameter int          Y_MAX     = 480,
    parameter int          WALL_W    = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input logic           pixel_clk,
    input logic           rst_n,
    wall_spawner_if.slave bus
);
    localparam int                 IDX_W     = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam logic [15:0]        SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(X_MAX - WALL_W);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(Y_MAX - WALL_W);

    typedef enum logic [1:0] {
        IDLE,
        DRAW_X,
        DRAW_Y,
        COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q;
    logic [COORD_W-1:0]   cand;
    logic [IDX_W-1:0]     tgt_q, tgt_d, empty_idx;
    logic                 empty_found;
    logic [COORD_W-1:0]   x_lat_q, x_lat_d;
    logic [COORD_W-1:0]   y_lat_q, y_lat_d;
    logic                 commit;
    logic [COORD_W-1:0]   slot_x [NUM_WALLS];
    logic [COORD_W-1:0]   slot_y [NUM_WALLS];
    logic [NUM_WALLS-1:0] valid_q;
    logic                 spawned_q;

    // Candidate is taken from the pre-shift LFSR value.
    assign cand = lfsr_q[COORD_W-1:0];

    // LFSR x^16+x^14+x^13+x^11+1; a seed load overrides the shift and zero maps to 1.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_INIT;
        end else if (bus.seed_load) begin
            lfsr_q <= (bus.seed_data == 16'h0000) ? 16'h0001 : bus.seed_data;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Priority encoder: lowest-numbered empty slot.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
        empty_found = 1'b0;
        empty_idx   = '0;
        for (int i = NUM_WALLS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                empty_found = 1'b1;
                empty_idx   = IDX_W'(i);
            end
        end
    end

    // FSM state and draw latches.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            x_lat_q <= '0;
            y_lat_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
            state_q <= state_d;
            tgt_q   <= tgt_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
        end
    end

    // Next-state logic: pick a slot, draw x then y with rejection, then commit.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        x_lat_d = x_lat_q;
        y_lat_d = y_lat_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.spawn_en && empty_found) begin
                    tgt_d   = empty_idx;
                    state_d = DRAW_X;
                end
            end
            DRAW_X: begin
                if (cand <= X_LIM) begin
                    x_lat_d = cand;
                    state_d = DRAW_Y;
                end
            end
            DRAW_Y: begin
                if (cand <= Y_LIM) begin
                    y_lat_d = cand;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot storage: a commit to a slot wins over a clear of the same slot.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: slot storage is reset explicitly because the renderer reads it as soon as reset lifts.
            slot_x    <= '{default: '0};
            slot_y    <= '{default: '0};
            valid_q   <= '0;
            spawned_q <= 1'b0;
        end else begin
            spawned_q <= commit;
            for (int i = 0; i < NUM_WALLS; i++) begin
                if (commit && (tgt_q == IDX_W'(i))) begin
                    slot_x[i]  <= x_lat_q;
                    slot_y[i]  <= y_lat_q;
                    valid_q[i] <= 1'b1;
                end else if (bus.clear[i]) begin
                    slot_x[i]  <= '0;
                    slot_y[i]  <= '0;
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Pack slot registers onto the flat coordinate buses.
    always_comb begin
        bus.wall_x = '0;
        bus.wall_y = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            bus.wall_x[i*COORD_W +: COORD_W] = slot_x[i];
            bus.wall_y[i*COORD_W +: COORD_W] = slot_y[i];
        end
    end

    assign bus.wall_valid = valid_q;
    assign bus.spawned    = spawned_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
